// File: rtl/lcd_pixel_scanner_if.sv
// Pixel stream from the raster scanner to the LCD frame writer.
// The master holds pixel_data/pixel_valid; the slave answers with pixel_ready.
interface lcd_pixel_scanner_if;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (output pixel_data, output pixel_valid, input pixel_ready);
    modport slave  (input pixel_data, input pixel_valid, output pixel_ready);
endinterface

// File: rtl/lcd_pixel_scanner.sv
// Raster-scan sequencer: walks (x,y) over one frame per start request and turns the
// OR-combined glyph hit into one colour word per pixel on a valid/ready stream.
module lcd_pixel_scanner #(
    parameter int          WIDTH     = 320,
    parameter int          HEIGHT    = 240,
    parameter logic [15:0] FG_COLOUR = 16'hFFFF,
    parameter logic [15:0] BG_COLOUR = 16'h0000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic [8:0]                  x,
    output logic [7:0]                  y,
    input  logic                        active,
    lcd_pixel_scanner_if.master         pix,
    output logic                        busy,
    output logic                        frame_done
);
    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t      state, state_n;
    logic [8:0]  x_n;
    logic [7:0]  y_n;
    logic [15:0] data_q, data_n;
    logic        valid_q, valid_n;
    logic        done_n;
    logic        load;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            data_q     <= BG_COLOUR;
            valid_q    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            data_q     <= data_n;
            valid_q    <= valid_n;
            frame_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        data_n  = data_q;
        valid_n = valid_q;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                x_n = '0;
                y_n = '0;
                if (start) state_n = SCAN;
            end
            SCAN: begin
                // A slot is free when nothing is held or the held pixel leaves this edge.
                load = !valid_q || pix.pixel_ready;
                if (load) begin
                    data_n  = active ? FG_COLOUR : BG_COLOUR;
                    valid_n = 1'b1;
                    if (x == X_LAST) begin
                        x_n = '0;
                        if (y == Y_LAST) begin
                            y_n     = '0;
                            state_n = DRAIN;
                        end else begin
                            y_n = y + 8'd1;
                        end
                    end else begin
                        x_n = x + 9'd1;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && pix.pixel_ready) begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy            = (state != IDLE);
    assign pix.pixel_data  = data_q;
    assign pix.pixel_valid = valid_q;
endmodule
